// File: rtl/fa_pkg.sv
// Shared definitions for the ripple-carry adder unit: the width limit, the
// sum-plus-carry record and a behavioural reference sum.
package fa_pkg;

    localparam int FA_MAX_WIDTH = 64;

    // Sum plus carry-out, sized for the widest legal adder; narrower adders
    // use the low WIDTH bits of s and keep the upper bits at zero.
    typedef struct packed {
        logic                    cout;
        logic [FA_MAX_WIDTH-1:0] s;
    } fa_sum_t;

    // Reference result of a + b + cin over width+1 bits. Operands are
    // zero-extended to FA_MAX_WIDTH by the caller and masked here to width.
    function automatic fa_sum_t fa_ref(input logic [FA_MAX_WIDTH-1:0] a,
                                       input logic [FA_MAX_WIDTH-1:0] b,
                                       input logic                    cin,
                                       input int                      width);
        logic [FA_MAX_WIDTH-1:0] mask;
        logic [FA_MAX_WIDTH:0]   full;
        fa_sum_t                 r;
        mask = (width >= FA_MAX_WIDTH) ? '1
                                       : ((FA_MAX_WIDTH'(1) << width) - FA_MAX_WIDTH'(1));
        full = {1'b0, a & mask} + {1'b0, b & mask} + {{FA_MAX_WIDTH{1'b0}}, cin};
        r.cout = |(full & ((FA_MAX_WIDTH+1)'(1) << width));
        r.s    = full[FA_MAX_WIDTH-1:0] & mask;
        return r;
    endfunction

endpackage

// File: rtl/half_adder.sv
// Half adder leaf: sum is the XOR of the inputs, carry is their AND.
module half_adder (
    input  logic a,
    input  logic b,
    output logic s,
    output logic c
);

    assign s = a ^ b;
    assign c = a & b;

endmodule

// File: rtl/ha_full_adder_unit.sv
// Registered WIDTH-bit ripple-carry adder. Each bit is two half adders with
// an OR merging their carries. Outputs update one cycle after a valid input
// and hold otherwise; out_valid flags a freshly captured result.
// Optional build macro FA_OVERFLOW_EN adds the registered signed-overflow
// output Ovf.
module ha_full_adder_unit
    import fa_pkg::*;
#(
    parameter int WIDTH = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             Cin,
    output logic             out_valid,
    output logic [WIDTH-1:0] S,
`ifdef FA_OVERFLOW_EN
    output logic             Ovf,
`endif
    output logic             Cout
);

    logic [WIDTH-1:0] s_comb;
    logic             c_last;
    logic             c_prev;

    // Each slice keeps its own carry-in/carry-out so the chain is a series
    // of scalar nets rather than one vector feeding back into itself.
    for (genvar i = 0; i < WIDTH; i++) begin : g_bit
        logic c_in;
        logic c_out;
        logic p;
        logic g;
        logic t;

        if (i == 0) begin : g_first
            assign c_in = Cin;
        end else begin : g_next
            assign c_in = g_bit[i-1].c_out;
        end

        half_adder u_ha_pg (
            .a (A[i]),
            .b (B[i]),
            .s (p),
            .c (g)
        );

        half_adder u_ha_sum (
            .a (p),
            .b (c_in),
            .s (s_comb[i]),
            .c (t)
        );

        assign c_out = g | t;
    end

    assign c_last = g_bit[WIDTH-1].c_out;
    assign c_prev = g_bit[WIDTH-1].c_in;

    // Capture the sum on valid input; hold the result and drop out_valid otherwise.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            S         <= '0;
            Cout      <= 1'b0;
`ifdef FA_OVERFLOW_EN
            Ovf       <= 1'b0;
`endif
        end else if (in_valid) begin
            out_valid <= 1'b1;
            S         <= s_comb;
            Cout      <= c_last;
`ifdef FA_OVERFLOW_EN
            Ovf       <= c_last ^ c_prev;
`endif
        end else begin
            out_valid <= 1'b0;
        end
    end

    // c_prev feeds only the overflow term; keep it referenced in every build.
    logic unused_c_prev;
    assign unused_c_prev = c_prev;

`ifndef SYNTHESIS
    // Cross-check the ripple chain against the behavioural sum at each capture.
    always @(posedge clk) begin
        if (rst_n && in_valid && !$isunknown({A, B, Cin})) begin
            assert (fa_ref(FA_MAX_WIDTH'(A), FA_MAX_WIDTH'(B), Cin, WIDTH)
                    == {c_last, FA_MAX_WIDTH'(s_comb)})
                else $error("ripple sum disagrees with reference");
        end
    end
`endif

endmodule

// File: tb/tb_ha_full_adder_unit.sv
// Directed bench for ha_full_adder_unit: a 1-bit instance and an 8-bit
// instance share clock, reset and in_valid.
module tb_ha_full_adder_unit;

    logic       clk;
    logic       rst_n;
    logic       in_valid;
    logic       a1, b1, cin1;
    logic       s1, cout1, ov1;
    logic [7:0] a8, b8, s8;
    logic       cin8, cout8, ov8;
`ifdef FA_OVERFLOW_EN
    logic       ovf1, ovf8;
`endif

    int checks = 0;
    int errors = 0;

    ha_full_adder_unit #(.WIDTH(1)) u_dut1 (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .A         (a1),
        .B         (b1),
        .Cin       (cin1),
        .out_valid (ov1),
        .S         (s1),
`ifdef FA_OVERFLOW_EN
        .Ovf       (ovf1),
`endif
        .Cout      (cout1)
    );

    ha_full_adder_unit #(.WIDTH(8)) u_dut8 (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .A         (a8),
        .B         (b8),
        .Cin       (cin8),
        .out_valid (ov8),
        .S         (s8),
`ifdef FA_OVERFLOW_EN
        .Ovf       (ovf8),
`endif
        .Cout      (cout8)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp)
            else begin
                errors++;
                $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
            end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // 1-bit truth table, indexed by {A,B,Cin}.
    logic [7:0] tt_s = 8'b1001_0110;
    logic [7:0] tt_c = 8'b1110_1000;

    // 8-bit vectors with hand-computed results.
    logic [7:0] v8_a   [8] = '{8'hFF, 8'h00, 8'h7F, 8'h3C, 8'h80, 8'hAA, 8'h12, 8'hFF};
    logic [7:0] v8_b   [8] = '{8'h01, 8'h00, 8'h01, 8'h5A, 8'h80, 8'h55, 8'h34, 8'hFF};
    logic       v8_cin [8] = '{1'b0,  1'b1,  1'b0,  1'b1,  1'b0,  1'b1,  1'b0,  1'b1};
    logic [7:0] v8_s   [8] = '{8'h00, 8'h01, 8'h80, 8'h97, 8'h00, 8'h00, 8'h46, 8'hFF};
    logic       v8_c   [8] = '{1'b1,  1'b0,  1'b0,  1'b0,  1'b1,  1'b1,  1'b0,  1'b1};
    logic       v8_ovf [8] = '{1'b0,  1'b0,  1'b1,  1'b1,  1'b1,  1'b0,  1'b0,  1'b0};

    initial begin
        logic [2:0] v;
        rst_n    = 1'b0;
        in_valid = 1'b0;
        a1 = 1'b0; b1 = 1'b0; cin1 = 1'b0;
        a8 = 8'h00; b8 = 8'h00; cin8 = 1'b0;
        #1;
        chk("rst_ov1", ov1, 0);
        chk("rst_s1", s1, 0);
        chk("rst_c1", cout1, 0);
        chk("rst_s8", s8, 0);

        // Reset dominates a valid input across several edges.
        a1 = 1'b1; b1 = 1'b1; cin1 = 1'b1; in_valid = 1'b1;
        a8 = 8'hFF; b8 = 8'h01; cin8 = 1'b0;
        for (int k = 0; k < 3; k++) begin
            tick();
            chk("rsthold_s1", s1, 0);
            chk("rsthold_c1", cout1, 0);
            chk("rsthold_ov1", ov1, 0);
            chk("rsthold_ov8", ov8, 0);
        end
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        chk("rel_s1", s1, 1);
        chk("rel_c1", cout1, 1);
        chk("rel_ov1", ov1, 1);
        chk("rel_s8", s8, 8'h00);
        chk("rel_c8", cout8, 1);

        // Back-to-back valid vectors: exhaustive 1-bit, directed 8-bit.
        for (int i = 0; i < 8; i++) begin
            v = 3'(i);
            a1 = v[2]; b1 = v[1]; cin1 = v[0];
            a8 = v8_a[i]; b8 = v8_b[i]; cin8 = v8_cin[i];
            tick();
            chk($sformatf("tt_s1[%0d]", i), s1, tt_s[v]);
            chk($sformatf("tt_c1[%0d]", i), cout1, tt_c[v]);
            chk($sformatf("tt_ov1[%0d]", i), ov1, 1);
            chk($sformatf("v8_s[%0d]", i), s8, v8_s[i]);
            chk($sformatf("v8_c[%0d]", i), cout8, v8_c[i]);
            chk($sformatf("v8_ov[%0d]", i), ov8, 1);
`ifdef FA_OVERFLOW_EN
            chk($sformatf("tt_ovf1[%0d]", i), ovf1, tt_c[v] ^ v[0]);
            chk($sformatf("v8_ovf[%0d]", i), ovf8, v8_ovf[i]);
`endif
        end

        // Hold: capture, then change inputs with in_valid low.
        a1 = 1'b1; b1 = 1'b0; cin1 = 1'b0;
        a8 = 8'h12; b8 = 8'h34; cin8 = 1'b0;
        tick();
        chk("cap_s1", s1, 1);
        chk("cap_s8", s8, 8'h46);
        in_valid = 1'b0;
        a1 = 1'b1; b1 = 1'b1; cin1 = 1'b1;
        a8 = 8'hFF; b8 = 8'hFF; cin8 = 1'b1;
        for (int k = 0; k < 2; k++) begin
            tick();
            chk("hold_s1", s1, 1);
            chk("hold_c1", cout1, 0);
            chk("hold_ov1", ov1, 0);
            chk("hold_s8", s8, 8'h46);
            chk("hold_c8", cout8, 0);
            chk("hold_ov8", ov8, 0);
`ifdef FA_OVERFLOW_EN
            chk("hold_ovf8", ovf8, 0);
`endif
        end

        // Asynchronous reset between edges while a result is valid.
        in_valid = 1'b1;
        a8 = 8'h7F; b8 = 8'h01; cin8 = 1'b0;
        tick();
        chk("pre_ov1", ov1, 1);
        chk("pre_s1", s1, 1);
        chk("pre_s8", s8, 8'h80);
        #2;
        rst_n = 1'b0;
        #1;
        chk("async_ov1", ov1, 0);
        chk("async_s1", s1, 0);
        chk("async_c1", cout1, 0);
        chk("async_ov8", ov8, 0);
        chk("async_s8", s8, 8'h00);
`ifdef FA_OVERFLOW_EN
        chk("async_ovf8", ovf8, 0);
`endif
        @(negedge clk);
        rst_n = 1'b1;
        a1 = 1'b0; b1 = 1'b1; cin1 = 1'b1;
        a8 = 8'h00; b8 = 8'h00; cin8 = 1'b1;
        tick();
        chk("post_s1", s1, 0);
        chk("post_c1", cout1, 1);
        chk("post_ov1", ov1, 1);
        chk("post_s8", s8, 8'h01);
        chk("post_c8", cout8, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/ha_full_adder_unit.md
Name: ha_full_adder_unit

Overview:
Registered N-bit ripple-carry adder. Each bit slice is a full adder built from two half adders plus an OR for carry. With WIDTH=1 (default) it is a single-bit full adder: S = A^B^Cin, Cout = majority(A,B,Cin). It is used as an arithmetic leaf cell in datapaths. Outputs are registered, with a simple valid qualifier.

Parameters:
WIDTH, 1, operand and sum width in bits (legal range 1..64).

Ports:
clk  input  1  rising-edge clock.
rst_n  input  1  asynchronous active-low reset.
in_valid  input  1  operands valid this cycle; capture enable.
A  input  WIDTH  addend A (unsigned bit vector).
B  input  WIDTH  addend B.
Cin  input  1  carry into bit 0.
out_valid  output  1  S/Cout hold a result captured from a valid input.
S  output  WIDTH  registered sum, bits [WIDTH-1:0].
Cout  output  1  registered carry out of bit WIDTH-1.

Behaviour:
- Reset is asynchronous and active-low. While rst_n=0: S=0, Cout=0, out_valid=0, regardless of clk. Reset has priority over capture. Release is sampled at the next rising clk edge.
- Combinational core, bit i:
  - half adder 1: p_i = A_i ^ B_i, g_i = A_i & B_i.
  - half adder 2: s_i = p_i ^ c_i, t_i = p_i & c_i.
  - c_{i+1} = g_i | t_i, with c_0 = Cin.
  - Pure ripple; no lookahead.
- Arithmetic identity: {c_WIDTH, s} = A + B + Cin, computed exactly over WIDTH+1 bits. No saturation; the result wraps modulo 2^WIDTH and the excess goes to Cout.
- Latency is 1 cycle. On a rising edge with in_valid=1: S<=s, Cout<=c_WIDTH, out_valid<=1.
- On a rising edge with in_valid=0: S and Cout hold their previous values; out_valid<=0.
- Back-to-back valid inputs are accepted every cycle. There is no backpressure and no ready signal.
- Reset asserted mid-operation discards any in-flight result. The first valid input after release produces out_valid one cycle later.
- X on an input is not masked; correctness is only required for 0/1 inputs.

Optional Feature:
Macro FA_OVERFLOW_EN.
- Defined: adds output port Ovf (1 bit), registered alongside S. Ovf = c_WIDTH ^ c_{WIDTH-1}, the signed two's-complement overflow. For WIDTH=1 this is Cout ^ Cin. Ovf is reset to 0 and holds when in_valid=0, exactly like Cout.
- Undefined: the port and its logic are absent; all other behaviour is identical.

Decomposition:
- Shared package fa_pkg holds:
  - localparam FA_MAX_WIDTH = 64;
  - a typedef for the sum-plus-carry struct {logic cout; logic [WIDTH-1:0] s;} as a parameterized helper;
  - the function fa_ref(a,b,cin) returning the WIDTH+1-bit reference sum, shared by RTL assertions and the bench.
- One sub-module is natural: half_adder (inputs a, b; outputs s = a^b, c = a&b), instantiated twice per bit inside a generate loop. No separate full-adder cell module.

Test Plan:
- WIDTH=1 exhaustive: drive all 8 {A,B,Cin} combinations with in_valid=1, one per cycle. Required (S,Cout): 000->(0,0), 001->(1,0), 010->(1,0), 011->(0,1), 100->(1,0), 101->(0,1), 110->(0,1), 111->(1,1), each appearing one cycle after its input.
- Reset: hold rst_n=0 with A=1, B=1, Cin=1, in_valid=1 and toggle clk. S=0, Cout=0 and out_valid=0 throughout. After release, the next edge gives S=1, Cout=1 and out_valid=1.
- Hold: capture A=1, B=0, Cin=0 (S=1), then set in_valid=0 and change inputs to 1,1,1. S stays 1, Cout stays 0, and out_valid drops to 0.
- WIDTH=8 wrap: A=0xFF, B=0x01, Cin=0 gives S=0x00, Cout=1. A=0x00, B=0x00, Cin=1 gives S=0x01, Cout=0.
- FA_OVERFLOW_EN with WIDTH=8: A=0x7F, B=0x01, Cin=0 gives S=0x80, Cout=0, Ovf=1. A=0xFF, B=0x01 gives Ovf=0.
- Asynchronous reset mid-stream: assert rst_n=0 between clock edges while out_valid=1. The outputs clear immediately, without waiting for the clock.
